// File: rtl/aoi_pkg.sv
// Shared types and golden model for the aoi_pipe AND-OR-INVERT / OR-AND-INVERT evaluator.
// aoi_ref() is the single reference used by both the in-design self-check and the testbench.
package aoi_pkg;

  typedef enum logic {
    AOI_MODE_AOI = 1'b0,
    AOI_MODE_OAI = 1'b1
  } aoi_mode_e;

  // Widest single-lane vector aoi_ref() can evaluate (N_GROUPS*GROUP_W).
  localparam int AOI_MAX_W = 256;

  function automatic logic aoi_ref(input logic [AOI_MAX_W-1:0] vec,
                                   input aoi_mode_e             mode,
                                   input int                    group_w,
                                   input int                    n_groups);
    logic [AOI_MAX_W-1:0] mask;
    logic [AOI_MAX_W-1:0] grp;
    logic                 term;
    logic                 any_t;
    logic                 all_t;
    mask  = {AOI_MAX_W{1'b1}} >> (AOI_MAX_W - group_w);
    any_t = 1'b0;
    all_t = 1'b1;
    for (int g = 0; g < n_groups; g++) begin
      grp   = (vec >> (g * group_w)) & mask;
      term  = (mode == AOI_MODE_AOI) ? (grp == mask) : (grp != '0);
      any_t = any_t | term;
      all_t = all_t & term;
    end
    return (mode == AOI_MODE_AOI) ? ~any_t : ~all_t;
  endfunction

endpackage

// File: rtl/aoi_pipe_slice.sv
// Generic valid/ready register slice: one entry, full throughput when the consumer is ready.
module aoi_pipe_slice #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d, data_q;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/aoi_pipe.sv
// Two-stage elastic AOI/OAI evaluator: stage 1 registers per-group AND/OR terms, stage 2 the inverted lane result.
// Define AOI_PIPE_CHECK_EN to carry raw inputs alongside and flag mismatches against aoi_ref() on chk_err.
module aoi_pipe
  import aoi_pkg::*;
#(
  parameter int GROUP_W  = 2,
  parameter int N_GROUPS = 2,
  parameter int LANES    = 1,
  parameter int CNT_W    = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_mode,
  input  logic [LANES*N_GROUPS*GROUP_W-1:0]  in_a,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [LANES-1:0]                   out_o,
  output logic                               out_mode,
  output logic [CNT_W-1:0]                   xfer_cnt,
  output logic                               chk_err
);

  localparam int TERMS_W = LANES * N_GROUPS;
  localparam int IN_W    = TERMS_W * GROUP_W;
  localparam int LANE_W  = N_GROUPS * GROUP_W;
`ifdef AOI_PIPE_CHECK_EN
  localparam int SHADOW_W = IN_W;
`else
  localparam int SHADOW_W = 0;
`endif
  localparam int S1_W = SHADOW_W + TERMS_W + 1;
  localparam int S2_W = SHADOW_W + LANES + 1;

  logic [TERMS_W-1:0] terms_d, terms_q;
  logic [LANES-1:0]   o_d;
  logic               mode_q;
  logic [S1_W-1:0]    s1_in, s1_out;
  logic [S2_W-1:0]    s2_in, s2_out;
  logic               s1_valid, s1_ready;
  logic               out_fire;
  logic [CNT_W-1:0]   xfer_cnt_d, xfer_cnt_q;

  for (genvar t = 0; t < TERMS_W; t++) begin : g_term
    assign terms_d[t] = (in_mode == AOI_MODE_OAI) ? |in_a[t*GROUP_W +: GROUP_W]
                                                  : &in_a[t*GROUP_W +: GROUP_W];
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign o_d[l] = (mode_q == AOI_MODE_OAI) ? ~&terms_q[l*N_GROUPS +: N_GROUPS]
                                             : ~|terms_q[l*N_GROUPS +: N_GROUPS];
  end

  // Payload layout, LSB first: result bits, mode, then the optional raw-input shadow.
  always_comb begin
`ifdef AOI_PIPE_CHECK_EN
    s1_in = {in_a, in_mode, terms_d};
    s2_in = {s1_out[S1_W-1 -: IN_W], mode_q, o_d};
`else
    s1_in = {in_mode, terms_d};
    s2_in = {mode_q, o_d};
`endif
    terms_q = s1_out[TERMS_W-1:0];
    mode_q  = s1_out[TERMS_W];
  end

  aoi_pipe_slice #(.DATA_W(S1_W)) u_stage1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s1_ready),
    .out_data  (s1_out)
  );

  aoi_pipe_slice #(.DATA_W(S2_W)) u_stage2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s1_ready),
    .in_data   (s2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_out)
  );

  assign out_o    = s2_out[LANES-1:0];
  assign out_mode = s2_out[LANES];
  assign out_fire = out_valid && out_ready;
  assign xfer_cnt = xfer_cnt_q;

  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (out_fire) xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) xfer_cnt_q <= '0;
    else     xfer_cnt_q <= xfer_cnt_d;
  end

`ifdef AOI_PIPE_CHECK_EN
  logic [IN_W-1:0]  raw_q;
  logic [LANES-1:0] ref_o;
  logic             chk_err_d, chk_err_q;

  assign raw_q = s2_out[S2_W-1 -: IN_W];

  for (genvar l = 0; l < LANES; l++) begin : g_ref
    assign ref_o[l] = aoi_ref(AOI_MAX_W'(raw_q[l*LANE_W +: LANE_W]), aoi_mode_e'(out_mode),
                              GROUP_W, N_GROUPS);
  end

  always_comb begin
    chk_err_d = chk_err_q;
    if (out_fire && (out_o != ref_o)) chk_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chk_err_q <= 1'b0;
    else     chk_err_q <= chk_err_d;
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_aoi_pipe.sv
// Directed self-checking bench for aoi_pipe: latency, modes, stall/backpressure, reset, counter wrap,
// degenerate 1x1 geometry and a randomised multi-lane run scored against aoi_ref().
module tb_aoi_pipe;
  import aoi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Default geometry, 16-bit counter
  logic        a_valid = 0, a_ready, a_mode = 0, a_ovalid, a_oready = 0, a_omode, a_err;
  logic [3:0]  a_in = '0;
  logic [0:0]  a_o;
  logic [15:0] a_cnt;

  aoi_pipe #(.GROUP_W(2), .N_GROUPS(2), .LANES(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .in_mode(a_mode), .in_a(a_in),
    .out_valid(a_ovalid), .out_ready(a_oready), .out_o(a_o), .out_mode(a_omode),
    .xfer_cnt(a_cnt), .chk_err(a_err));

  // Degenerate 1x1 geometry with a 4-bit counter
  logic        b_valid = 0, b_ready, b_mode = 0, b_ovalid, b_oready = 0, b_omode, b_err;
  logic [0:0]  b_in = '0;
  logic [0:0]  b_o;
  logic [3:0]  b_cnt;

  aoi_pipe #(.GROUP_W(1), .N_GROUPS(1), .LANES(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_mode(b_mode), .in_a(b_in),
    .out_valid(b_ovalid), .out_ready(b_oready), .out_o(b_o), .out_mode(b_omode),
    .xfer_cnt(b_cnt), .chk_err(b_err));

  // Wide multi-lane geometry
  logic        c_valid = 0, c_ready, c_mode = 0, c_ovalid, c_oready = 0, c_omode, c_err;
  logic [35:0] c_in = '0;
  logic [2:0]  c_o;
  logic [15:0] c_cnt;

  aoi_pipe #(.GROUP_W(3), .N_GROUPS(4), .LANES(3), .CNT_W(16)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(c_ready), .in_mode(c_mode), .in_a(c_in),
    .out_valid(c_ovalid), .out_ready(c_oready), .out_o(c_o), .out_mode(c_omode),
    .xfer_cnt(c_cnt), .chk_err(c_err));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic applyStimulus(input logic mode, input logic [3:0] data);
    a_valid = 1'b1;
    a_mode  = mode;
    a_in    = data;
  endtask

  function automatic logic [2:0] wideModel(input logic [35:0] v, input logic m);
    logic [2:0] r;
    for (int l = 0; l < 3; l++)
      r[l] = aoi_ref(AOI_MAX_W'(12'(v >> (l * 12))), aoi_mode_e'(m), 3, 4);
    return r;
  endfunction

  logic [3:0] t3_data [3] = '{4'b1010, 4'b1100, 4'b0000};
  logic       t3_mode [3] = '{1'b0, 1'b0, 1'b1};
  logic       t3_expo [3] = '{1'b1, 1'b0, 1'b1};
  logic       got_o [3];
  logic       got_m [3];
  logic       acc;
  logic [1:0] b_q [$];
  logic [3:0] c_q [$];

  initial begin
    int idx, n, stale, sent, got;
    logic c_acc;

    doReset();
    checkOutput("rst_out_valid", a_ovalid, 0);
    checkOutput("rst_out_o", a_o, 0);
    checkOutput("rst_out_mode", a_omode, 0);
    checkOutput("rst_xfer_cnt", a_cnt, 0);
    checkOutput("rst_chk_err", a_err, 0);
    checkOutput("rst_in_ready", a_ready, 1);
    checkOutput("rst_b_out_valid", b_ovalid, 0);
    checkOutput("rst_c_xfer_cnt", c_cnt, 0);

    // AOI single transactions and two-cycle latency
    a_oready = 1'b1;
    applyStimulus(1'b0, 4'b1100);
    tick();
    a_valid = 1'b0;
    checkOutput("t1_not_yet_valid", a_ovalid, 0);
    tick();
    checkOutput("t1_valid", a_ovalid, 1);
    checkOutput("t1_o_1100", a_o, 0);
    checkOutput("t1_mode", a_omode, 0);
    tick();
    checkOutput("t1_cnt1", a_cnt, 1);
    checkOutput("t1_drained", a_ovalid, 0);
    applyStimulus(1'b0, 4'b1010);
    tick();
    a_valid = 1'b0;
    tick();
    checkOutput("t1_valid2", a_ovalid, 1);
    checkOutput("t1_o_1010", a_o, 1);
    checkOutput("t1_mode2", a_omode, 0);
    tick();
    checkOutput("t1_cnt2", a_cnt, 2);

    // OAI back-to-back
    doReset();
    applyStimulus(1'b1, 4'b0000);
    tick();
    applyStimulus(1'b1, 4'b0110);
    tick();
    a_valid = 1'b0;
    checkOutput("t2_valid1", a_ovalid, 1);
    checkOutput("t2_o_0000", a_o, 1);
    checkOutput("t2_mode1", a_omode, 1);
    tick();
    checkOutput("t2_valid2", a_ovalid, 1);
    checkOutput("t2_o_0110", a_o, 0);
    checkOutput("t2_mode2", a_omode, 1);
    tick();
    checkOutput("t2_cnt", a_cnt, 2);
    checkOutput("t2_drained", a_ovalid, 0);

    // Backpressure: three offered, two fit, then all drain in order
    doReset();
    a_oready = 1'b0;
    idx = 0;
    applyStimulus(t3_mode[0], t3_data[0]);
    for (int c = 0; c < 5; c++) begin
      acc = a_valid && a_ready;
      tick();
      if (acc) begin
        idx++;
        if (idx < 3) applyStimulus(t3_mode[idx], t3_data[idx]);
        else a_valid = 1'b0;
      end
    end
    checkOutput("t3_accepted", idx, 2);
    checkOutput("t3_in_ready", a_ready, 0);
    checkOutput("t3_stall_valid", a_ovalid, 1);
    checkOutput("t3_stall_o", a_o, 1);
    checkOutput("t3_stall_mode", a_omode, 0);
    a_oready = 1'b1;
    #1;
    n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      if (a_ovalid && a_oready) begin
        got_o[n] = a_o[0];
        got_m[n] = a_omode;
        n++;
      end
      acc = a_valid && a_ready;
      tick();
      if (acc) begin
        idx++;
        if (idx < 3) applyStimulus(t3_mode[idx], t3_data[idx]);
        else a_valid = 1'b0;
      end
    end
    checkOutput("t3_all_accepted", idx, 3);
    checkOutput("t3_out_count", n, 3);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("t3_order_o%0d", k), got_o[k], t3_expo[k]);
      checkOutput($sformatf("t3_order_mode%0d", k), got_m[k], t3_mode[k]);
    end
    checkOutput("t3_cnt", a_cnt, 3);

    // Reset with two in flight
    a_oready = 1'b0;
    applyStimulus(1'b0, 4'b1010);
    tick();
    applyStimulus(1'b1, 4'b0000);
    tick();
    a_valid = 1'b0;
    checkOutput("t4_inflight", a_ovalid, 1);
    rst = 1'b1;
    tick();
    checkOutput("t4_rst_valid", a_ovalid, 0);
    rst = 1'b0;
    a_oready = 1'b1;
    tick();
    checkOutput("t4_cnt", a_cnt, 0);
    checkOutput("t4_out_o", a_o, 0);
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      if (a_ovalid) stale++;
      tick();
    end
    checkOutput("t4_stale", stale, 0);
    checkOutput("t4_cnt_after", a_cnt, 0);

    // Degenerate geometry: o = ~a in both modes, 4-bit counter wraps after 16
    b_oready = 1'b1;
    sent = 0;
    got = 0;
    acc = 1'b0;
    for (int c = 0; c < 200 && got < 17; c++) begin
      if (!b_valid || acc) begin
        if (sent < 17) begin
          b_valid = 1'b1;
          b_in    = 1'($urandom);
          b_mode  = 1'($urandom);
        end else b_valid = 1'b0;
      end
      #1;
      if (b_ovalid && b_oready) begin
        if (b_q.size() > 0) checkOutput("t5_o", {b_omode, b_o}, b_q.pop_front());
        else checkOutput("t5_unexpected", 1, 0);
        got++;
      end
      acc = b_valid && b_ready;
      if (acc) begin
        b_q.push_back({b_mode, ~b_in});
        sent++;
      end
      tick();
    end
    b_valid = 1'b0;
    checkOutput("t5_count", got, 17);
    checkOutput("t5_wrap", b_cnt, 1);
    checkOutput("t5_chk_err", b_err, 0);

    // Wide random run with random valid gaps and stalls
    sent = 0;
    got = 0;
    c_acc = 1'b0;
    for (int c = 0; c < 20000 && got < 1000; c++) begin
      if (!c_valid || c_acc) begin
        if (sent < 1000 && $urandom_range(0, 3) != 0) begin
          c_valid = 1'b1;
          c_in    = 36'({$urandom(), $urandom()});
          c_mode  = 1'($urandom);
        end else c_valid = 1'b0;
      end
      c_oready = ($urandom_range(0, 3) != 0);
      #1;
      if (c_ovalid && c_oready) begin
        if (c_q.size() > 0) checkOutput("t6_result", {c_omode, c_o}, c_q.pop_front());
        else checkOutput("t6_unexpected", 1, 0);
        got++;
      end
      c_acc = c_valid && c_ready;
      if (c_acc) begin
        c_q.push_back({c_mode, wideModel(c_in, c_mode)});
        sent++;
      end
      tick();
    end
    c_valid = 1'b0;
    checkOutput("t6_count", got, 1000);
    checkOutput("t6_xfer_cnt", c_cnt, 1000);
    checkOutput("t6_chk_err", c_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
